// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM state encoding,
// grant-owner encoding, default bus widths and the watchdog counter sizing.
package mem_bus_arbiter_pkg;

  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUS_IF = 2'd1,
    ST_BUS_EX = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_EX = 1'b1
  } gnt_e;

  // Watchdog counter is never narrower than 8 bits.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Bus watchdog: counts cycles while the bus request is up and flags expiry
// once the request has been outstanding for TIMEOUT_CYCLES cycles.
module mem_bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q is 0 in the first request cycle, so the last allowed cycle is LIMIT-1.
  assign expire = run & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between the fetch and data ports and raises
// pipeline stall requests. Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW             = DEFAULT_AW,
  parameter int unsigned DW             = DEFAULT_DW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ready,
  output logic [DW-1:0]   if_rdata,
  input  logic            ex_req,
  input  logic            ex_we,
  input  logic [AW-1:0]   ex_addr,
  input  logic [DW-1:0]   ex_wdata,
  input  logic [DW/8-1:0] ex_be,
  output logic            ex_ready,
  output logic [DW-1:0]   ex_rdata,
  input  logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            loadorder_ask,
  output logic            execute_ask,
  output logic            bus_err
);

  state_e            state_q, state_d;
  gnt_e              last_grant_q, last_grant_d;
  logic              drop_q, drop_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0]   mem_be_q, mem_be_d;
  logic              if_ready_q, if_ready_d, ex_ready_q, ex_ready_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d, ex_rdata_q, ex_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              if_ok, ex_ok, grant_if, grant_ex, expire, done;

  // A port whose ready is pulsing this cycle is ignored to prevent a duplicate grant.
  assign if_ok    = if_req & ~if_ready_q & ~flush;
  assign ex_ok    = ex_req & ~ex_ready_q;
  assign grant_if = (state_q == ST_IDLE) & if_ok & (~ex_ok | (last_grant_q == GNT_EX));
  assign grant_ex = (state_q == ST_IDLE) & ex_ok & ~grant_if;

`ifdef BUS_TIMEOUT_EN
  logic wd_expire;

  mem_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (grant_if | grant_ex),
    .run   (mem_req),
    .expire(wd_expire)
  );

  // A real acknowledge on the expiry cycle takes precedence.
  assign expire = wd_expire & ~mem_ack;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  assign done = mem_ack | expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          state_d = ST_BUS_IF;
        end else if (grant_ex) begin
          state_d = ST_BUS_EX;
        end
      end
      ST_BUS_IF, ST_BUS_EX: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    unique case (state_q)
      ST_BUS_IF, ST_BUS_EX: mem_req = 1'b1;
      default:              mem_req = 1'b0;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_rdata_d   = if_rdata_q;
    ex_rdata_d   = ex_rdata_q;
    if_ready_d   = 1'b0;
    ex_ready_d   = 1'b0;
    bus_err_d    = 1'b0;

    if (grant_if) begin
      last_grant_d = GNT_IF;
      drop_d       = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = if_addr;
      mem_wdata_d  = '0;
      mem_be_d     = '1;
    end else if (grant_ex) begin
      last_grant_d = GNT_EX;
      mem_we_d     = ex_we;
      mem_addr_d   = ex_addr;
      mem_wdata_d  = ex_wdata;
      mem_be_d     = ex_be;
    end

    if (state_q == ST_BUS_IF) begin
      if (flush) drop_d = 1'b1;
      if (done) begin
        drop_d = 1'b0;
        if (!(drop_q || flush)) begin
          if_ready_d = 1'b1;
          if_rdata_d = mem_ack ? mem_rdata : '0;
        end
      end
    end

    if (state_q == ST_BUS_EX && done) begin
      ex_ready_d = 1'b1;
      if (!mem_ack) begin
        ex_rdata_d = '0;
      end else if (!mem_we_q) begin
        ex_rdata_d = mem_rdata;
      end
    end

    if (state_q != ST_IDLE) bus_err_d = expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_EX;
      drop_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_ready_q   <= 1'b0;
      ex_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      ex_rdata_q   <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_ready_q   <= if_ready_d;
      ex_ready_q   <= ex_ready_d;
      if_rdata_q   <= if_rdata_d;
      ex_rdata_q   <= ex_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;
  assign if_ready      = if_ready_q;
  assign if_rdata      = if_rdata_q;
  assign ex_ready      = ex_ready_q;
  assign ex_rdata      = ex_rdata_q;
  assign bus_err       = bus_err_q;
  assign loadorder_ask = if_req & ~if_ready_q;
  assign execute_ask   = ex_req & ~ex_ready_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the instruction-load stage (fetch port) and the execute stage (data port).
- Owns a small grant FSM, registers the bus request, and returns read data to the winning requester.
- Generates the two pipeline-stall requests consumed by the pipeline timing controller: loadorder_ask and execute_ask.
- Sits between the pipeline stages and the external memory/cache interface.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables = DW/8)
TIMEOUT_CYCLES, 255, bus watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held high until if_ready
if_addr  in  AW  fetch address
if_ready  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetched instruction word
ex_req  in  1  data request, held high until ex_ready
ex_we  in  1  1 = write, 0 = read
ex_addr  in  AW  data address
ex_wdata  in  DW  write data
ex_be  in  DW/8  byte enables
ex_ready  out  1  one-cycle completion pulse
ex_rdata  out  DW  read data
flush  in  1  interrupt flush: discard the fetch result
mem_req  out  1  bus request, held until mem_ack
mem_we  out  1  bus write strobe
mem_addr  out  AW  bus address
mem_wdata  out  DW  bus write data
mem_be  out  DW/8  bus byte enables
mem_ack  in  1  bus completion, one cycle
mem_rdata  in  DW  bus read data, valid with mem_ack
loadorder_ask  out  1  fetch stall request
execute_ask  out  1  data stall request
bus_err  out  1  watchdog expiry pulse (tied 0 without the optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, last_grant = EX, all outputs 0, including the rdata registers. A transaction in flight is abandoned and mem_req drops immediately.
- FSM states: IDLE, BUS_IF, BUS_EX.
- IDLE:
  - If only one request is pending, grant it.
  - If both are pending, grant the port not granted last (alternating).
  - On grant: latch addr/we/wdata/be into the mem_* registers and raise mem_req on the next cycle.
  - The fetch port always drives mem_we = 0 and mem_be = all ones.
- BUS_IF / BUS_EX:
  - Hold mem_req and all mem_* outputs stable until mem_ack.
  - On mem_ack: drop mem_req, register mem_rdata into if_rdata or ex_rdata, pulse the matching ready in the following cycle, and return to IDLE.
  - Writes also pulse ex_ready; ex_rdata is left unchanged on writes.
- Minimum latency: request to ready is 3 cycles with mem_ack in the first cycle mem_req is high.
  - The cycle after a ready pulse, the FSM is in IDLE. The completed requester's req is ignored that cycle, so no duplicate grant can occur.
- Stall outputs (combinational):
  - loadorder_ask = if_req & ~if_ready.
  - execute_ask = ex_req & ~ex_ready.
- flush:
  - In BUS_IF, a flush on any cycle sets a drop flag. The bus transaction still completes, but if_ready is suppressed and if_rdata is not updated.
  - In IDLE, flush blocks a fetch grant for that cycle.
  - flush never affects the data port.
- Simultaneous mem_ack and flush: the fetch result is dropped.
- A mem_ack seen in IDLE is ignored.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - An 8-bit-min counter runs while mem_req is high and clears on grant.
  - When it reaches TIMEOUT_CYCLES, mem_req drops and the FSM returns to IDLE.
  - The owner's ready pulses with rdata = 0, and bus_err pulses 1 cycle.
  - A mem_ack arriving on the expiry cycle wins: normal completion, no bus_err.
- Undefined: no counter is built, bus_err is constant 0, and the FSM waits for mem_ack indefinitely.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE/ST_BUS_IF/ST_BUS_EX.
  - grant-owner constants GNT_IF/GNT_EX.
  - default AW/DW.
- One natural sub-module: mem_bus_watchdog (counter plus expiry compare), instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- Fetch only, if_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> if_ready pulses once with if_rdata=0xDEADBEEF; loadorder_ask high every cycle until that pulse.
- Both requests in the same cycle from reset -> IF granted first (last_grant=EX), then EX; across 4 back-to-back pairs the grants alternate IF,EX,IF,EX.
- Write ex_we=1, ex_be=4'b0011, ex_wdata=0x1234 -> mem_we=1, mem_be=0011, mem_wdata=0x1234 stable until mem_ack; ex_ready pulses; ex_rdata unchanged.
- flush asserted mid-BUS_IF -> mem_ack completes the bus cycle, no if_ready pulse, if_rdata unchanged, FSM in IDLE next cycle.
- rst_n low while mem_req=1 in BUS_EX -> mem_req=0 immediately (asynchronously); after release, state is IDLE and all outputs are 0.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ack never asserted -> bus_err and ex_ready pulse together after 8 cycles with ex_rdata=0; execute_ask drops.
